turn_manager: RTL and testbench

TURN_MANAGER -- requirements
Module: turn_manager

---
 rtl/turn_manager.sv | 153 +++++++++++++++
 tb/tb_turn_manager.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turn_manager.sv
// Two-player board-game turn sequencer: dice roll, move, animation handshake, win detection.
// Optional question-box bonus move on tile 3 is enabled by defining QBOX_BONUS_EN.
module turn_manager #(
    parameter int unsigned NUM_TILES  = 10,
    parameter int unsigned TILE_X0    = 20,
    parameter int unsigned TILE_PITCH = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_roll,
    input  logic       turn_done,
    output logic [9:0] player1_pos_x,
    output logic [9:0] player2_pos_x,
    output logic       pos_valid,
    output logic       active_player,
    output logic [2:0] dice_value,
    output logic       game_over,
    output logic       winner
);

`ifdef QBOX_BONUS_EN
    localparam bit BonusEn = 1'b1;
`else
    localparam bit BonusEn = 1'b0;
`endif

    // Wide enough to hold tile + 6 before clamping.
    localparam int unsigned TW = $clog2(NUM_TILES + 7);
    localparam logic [TW-1:0] LastTile = TW'(NUM_TILES);
    localparam logic [9:0] StartX = 10'(TILE_X0);

    typedef enum logic [2:0] {
        StIdle,
        StMove,
        StWaitDone,
        StBonus,
        StSwitch,
        StOver
    } state_e;

    state_e        state_q;
    logic          phase_q;
    logic          bonus_q;
    logic          btn_prev_q;
    logic          btn_seen_q;
    logic [2:0]    dice_cnt_q;
    logic [2:0]    dice_q;
    logic [TW-1:0] tile1_q;
    logic [TW-1:0] tile2_q;
    logic [9:0]    pos1_q;
    logic [9:0]    pos2_q;
    logic          pos_valid_q;
    logic          active_q;
    logic          game_over_q;
    logic          winner_q;

    logic          roll_req;
    logic [TW-1:0] cur_tile;
    logic [TW-1:0] step;
    logic [TW-1:0] sum;
    logic [TW-1:0] new_tile;
    logic [9:0]    cur_pos;

    always_comb begin
        // btn_seen_q blocks a level held high across reset from looking like a fresh edge.
        roll_req = btn_roll && !btn_prev_q && btn_seen_q;
        cur_tile = active_q ? tile2_q : tile1_q;
        step     = (state_q == StBonus) ? TW'(2) : TW'(dice_q);
        sum      = cur_tile + step;
        new_tile = (sum > LastTile) ? LastTile : sum;
        cur_pos  = 10'(TILE_X0 + TILE_PITCH * 32'(cur_tile));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            phase_q     <= 1'b0;
            bonus_q     <= 1'b0;
            btn_prev_q  <= 1'b0;
            btn_seen_q  <= 1'b0;
            dice_cnt_q  <= 3'd1;
            dice_q      <= 3'd0;
            tile1_q     <= '0;
            tile2_q     <= '0;
            pos1_q      <= StartX;
            pos2_q      <= StartX;
            pos_valid_q <= 1'b0;
            active_q    <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
        end else begin
            btn_prev_q  <= btn_roll;
            btn_seen_q  <= 1'b1;
            dice_cnt_q  <= (dice_cnt_q == 3'd6) ? 3'd1 : dice_cnt_q + 3'd1;
            pos_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (roll_req) begin
                        dice_q  <= dice_cnt_q;
                        phase_q <= 1'b0;
                        state_q <= StMove;
                    end
                end
                StMove, StBonus: begin
                    // Phase 0 commits the tile, phase 1 publishes its position.
                    if (!phase_q) begin
                        if (active_q) tile2_q <= new_tile;
                        else          tile1_q <= new_tile;
                        if (state_q == StMove) bonus_q <= BonusEn && (sum == TW'(3));
                        phase_q <= 1'b1;
                    end else begin
                        if (active_q) pos2_q <= cur_pos;
                        else          pos1_q <= cur_pos;
                        pos_valid_q <= 1'b1;
                        phase_q     <= 1'b0;
                        state_q     <= StWaitDone;
                    end
                end
                StWaitDone: begin
                    if (turn_done) begin
                        if (cur_tile == LastTile) begin
                            game_over_q <= 1'b1;
                            winner_q    <= active_q;
                            state_q     <= StOver;
                        end else if (bonus_q) begin
                            bonus_q <= 1'b0;
                            state_q <= StBonus;
                        end else begin
                            state_q <= StSwitch;
                        end
                    end
                end
                StSwitch: begin
                    active_q <= ~active_q;
                    state_q  <= StIdle;
                end
                StOver: begin
                    state_q <= StOver;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign player1_pos_x = pos1_q;
    assign player2_pos_x = pos2_q;
    assign pos_valid     = pos_valid_q;
    assign active_player = active_q;
    assign dice_value    = dice_q;
    assign game_over     = game_over_q;
    assign winner        = winner_q;

endmodule

// File: tb/tb_turn_manager.sv
// Randomized scoreboard bench for turn_manager: a board-level model predicts every pos_valid
// pulse (positions, player, dice, cycle of arrival); a monitor pops and compares.
module tb_turn_manager;
    localparam int NT = 10;
    localparam int X0 = 20;
    localparam int PITCH = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_roll = 1'b0;
    logic       turn_done = 1'b0;
    logic [9:0] player1_pos_x;
    logic [9:0] player2_pos_x;
    logic       pos_valid;
    logic       active_player;
    logic [2:0] dice_value;
    logic       game_over;
    logic       winner;

    turn_manager #(.NUM_TILES(NT), .TILE_X0(X0), .TILE_PITCH(PITCH)) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_roll     (btn_roll),
        .turn_done    (turn_done),
        .player1_pos_x(player1_pos_x),
        .player2_pos_x(player2_pos_x),
        .pos_valid    (pos_valid),
        .active_player(active_player),
        .dice_value   (dice_value),
        .game_over    (game_over),
        .winner       (winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        int p1;
        int p2;
        int act;
        int dice;
        int at_edge;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   ec;          // rising edges since reset release
    int   m_tile[2];
    int   m_act;
    int   m_dice;
    bit   m_over;

    always @(posedge clk or posedge rst) begin
        if (rst) ec <= 0;
        else     ec <= ec + 1;
    end

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic int pos_of(input int t);
        return X0 + PITCH * t;
    endfunction

    function automatic int clamp(input int t);
        return (t > NT) ? NT : t;
    endfunction

    task automatic push_exp(input int at_edge);
        exp_t e;
        e.p1 = pos_of(m_tile[0]);
        e.p2 = pos_of(m_tile[1]);
        e.act = m_act;
        e.dice = m_dice;
        e.at_edge = at_edge;
        expq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && pos_valid) begin
            if (expq.size() == 0) begin
                chk("unexpected_pos_valid", 1, 0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("pv_latency_edge", ec, e.at_edge);
                chk("pv_player1_pos_x", int'(player1_pos_x), e.p1);
                chk("pv_player2_pos_x", int'(player2_pos_x), e.p2);
                chk("pv_active_player", int'(active_player), e.act);
                chk("pv_dice_value", int'(dice_value), e.dice);
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 12 && expq.size() != 0; i++) @(negedge clk);
        if (expq.size() != 0) begin
            chk("pos_valid_timeout", expq.size(), 0);
            expq.delete();
        end
    endtask

    task automatic do_reset(input bit hold_btn);
        @(negedge clk);
        #1;
        rst = 1'b1;
        btn_roll = hold_btn;
        turn_done = 1'b0;
        #1;
        chk("rst_player1_pos_x", int'(player1_pos_x), X0);
        chk("rst_player2_pos_x", int'(player2_pos_x), X0);
        chk("rst_pos_valid", int'(pos_valid), 0);
        chk("rst_active_player", int'(active_player), 0);
        chk("rst_dice_value", int'(dice_value), 0);
        chk("rst_game_over", int'(game_over), 0);
        chk("rst_winner", int'(winner), 0);
        expq.delete();
        m_tile[0] = 0;
        m_tile[1] = 0;
        m_act = 0;
        m_dice = 0;
        m_over = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_no_roll_dice", int'(dice_value), 0);
    endtask

    // Produce a fresh rising edge; want=0 picks a random moment, else waits for that dice value.
    task automatic press(input int want, output int d, output int acc);
        btn_roll = 1'b0;
        @(negedge clk);
        if (want == 0) repeat ($urandom_range(0, 5)) @(negedge clk);
        else while ((ec % 6) + 1 != want) @(negedge clk);
        d = (ec % 6) + 1;
        acc = ec + 1;
        btn_roll = 1'b1;
        @(negedge clk);
        if ($urandom_range(0, 1) == 1) btn_roll = 1'b0;
    endtask

    task automatic finish_anim(input bit bon_in);
        bit bon;
        bit done;
        int a;
        int tdone;
        bon = bon_in;
        done = 1'b0;
        a = m_act;
        while (!done) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            turn_done = 1'b1;
            if ($urandom_range(0, 3) == 0) btn_roll = 1'b1;
            tdone = ec + 1;
            @(negedge clk);
            turn_done = 1'b0;
            if (m_tile[a] == NT) begin
                m_over = 1'b1;
                chk("game_over", int'(game_over), 1);
                chk("winner", int'(winner), a);
                done = 1'b1;
            end else if (bon) begin
                bon = 1'b0;
                m_tile[a] = clamp(m_tile[a] + 2);
                push_exp(tdone + 2);
                drain();
            end else begin
                chk("active_hold_at_done", int'(active_player), m_act);
                @(negedge clk);
                m_act = 1 - m_act;
                chk("active_after_switch", int'(active_player), m_act);
                chk("game_over_low", int'(game_over), 0);
                done = 1'b1;
            end
        end
    endtask

    task automatic take_turn(input int want, input bit finish);
        int d;
        int acc;
        int a;
        bit bon;
        if (!m_over && $urandom_range(0, 3) == 0) begin
            turn_done = 1'b1;
            @(negedge clk);
            turn_done = 1'b0;
            repeat (2) @(negedge clk);
            chk("idle_turn_done_ignored", int'(active_player), m_act);
        end
        press(want, d, acc);
        if (m_over) begin
            repeat (6) @(negedge clk);
            chk("over_sticky", int'(game_over), 1);
            return;
        end
        chk("dice_latched", int'(dice_value), d);
        a = m_act;
        bon = 1'b0;
`ifdef QBOX_BONUS_EN
        bon = (m_tile[a] + d == 3);
`endif
        m_dice = d;
        m_tile[a] = clamp(m_tile[a] + d);
        push_exp(acc + 2);
        drain();
        if ($urandom_range(0, 2) == 0) begin
            btn_roll = 1'b0;
            @(negedge clk);
            btn_roll = 1'b1;
            @(negedge clk);
            btn_roll = 1'b0;
            repeat (2) @(negedge clk);
        end
        if (finish) finish_anim(bon);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        do_reset(1'b0);

        // First roll with counter=4 lands player 1 at x=260.
        take_turn(4, 1'b1);
        chk("first_move_p1_x", int'(player1_pos_x), 260);
        chk("first_move_p2_x", int'(player2_pos_x), 20);
        chk("first_move_active", int'(active_player), 1);

        // Drive player 1 to tile 8 then roll 6 for the win.
        do_reset(1'b0);
        take_turn(4, 1'b1);
        take_turn(1, 1'b1);
        take_turn(4, 1'b1);
        take_turn(1, 1'b1);
        take_turn(6, 1'b1);
        chk("win_p1_x", int'(player1_pos_x), 620);
        chk("win_flag", int'(game_over), 1);
        chk("win_winner", int'(winner), 0);
        take_turn(0, 1'b1);
        take_turn(0, 1'b1);

        // Question box landing.
        do_reset(1'b0);
        take_turn(3, 1'b1);
`ifdef QBOX_BONUS_EN
        chk("qbox_p1_x", int'(player1_pos_x), 320);
`else
        chk("qbox_p1_x", int'(player1_pos_x), 200);
`endif
        chk("qbox_switched", int'(active_player), 1);

        // Reset while waiting for the animation, button held through release.
        do_reset(1'b0);
        take_turn(6, 1'b0);
        chk("pre_rst_p1_x", int'(player1_pos_x), 380);
        do_reset(1'b1);
        chk("held_btn_p1_x", int'(player1_pos_x), 20);

        for (int g = 0; g < 4; g++) begin
            do_reset(1'($urandom_range(0, 1)));
            for (int t = 0; t < 80 && !m_over; t++) take_turn(0, 1'b1);
            chk("random_game_over", int'(game_over), 1);
            take_turn(0, 1'b1);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
